// File: rtl/nanotrade_pkg.sv
// Shared encodings and constants for the nanotrade alerting blocks.
package nanotrade_pkg;

  typedef enum logic [1:0] {
    CB_NORMAL   = 2'd0,
    CB_WARN     = 2'd1,
    CB_HALT     = 2'd2,
    CB_COOLDOWN = 2'd3
  } cb_state_e;

  localparam int ALERT_FLASH_BIT = 7;
  localparam logic [2:0] PRIO_FLASH = 3'd7;

endpackage

// File: rtl/alert_circuit_breaker_if.sv
// Alert bundle in, breaker status out; the slave side is the breaker itself.
interface alert_circuit_breaker_if;

  logic       alert_any;
  logic [2:0] alert_priority;
  logic [2:0] alert_type;
  logic [7:0] alert_bitmap;
  logic       ack;
  logic       trade_halt;
  logic [1:0] state;
  logic [7:0] sticky_bitmap;
  logic       latched_valid;
  logic [2:0] latched_type;
  logic [2:0] latched_prio;
  logic [7:0] event_count;
  logic [3:0] halt_count;
  logic       halt_irq;

  modport master (
    output alert_any, alert_priority, alert_type, alert_bitmap, ack,
    input  trade_halt, state, sticky_bitmap, latched_valid, latched_type,
           latched_prio, event_count, halt_count, halt_irq
  );

  modport slave (
    input  alert_any, alert_priority, alert_type, alert_bitmap, ack,
    output trade_halt, state, sticky_bitmap, latched_valid, latched_type,
           latched_prio, event_count, halt_count, halt_irq
  );

endinterface

// File: rtl/nt_sat_counter.sv
// Up-counter with clear and saturation: next = sat((clr ? 0 : count) + inc).
module nt_sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_base;

  assign w_base  = i_clr ? '0 : r_count;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= (i_inc && (w_base < MAX_V)) ? w_base + WIDTH'(1) : w_base;
  end

endmodule

// File: rtl/alert_circuit_breaker.sv
// Circuit breaker: sticky alert state plus a registered trade halt driven by
// a NORMAL/WARN/HALT/COOLDOWN FSM sharing one down-counting timer.
//   state    | meaning
//   NORMAL   | trading, no qualifying alert pending
//   WARN     | qualifying warning seen, quiet timer running
//   HALT     | trading halted, flash flags keep re-arming the timer
//   COOLDOWN | halt over, any flash flag re-halts immediately
module alert_circuit_breaker
  import nanotrade_pkg::*;
#(
  parameter int PERSIST     = 4,
  parameter int HOLD_CYCLES = 64,
  parameter int HALT_CYCLES = 256,
  parameter int WARN_PRIO   = 4
) (
  input logic                    clk,
  input logic                    rst,
  alert_circuit_breaker_if.slave cb
);

  localparam int TW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
  localparam logic [TW-1:0] HALT_LOAD = TW'(HALT_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  cb_state_e     r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_halt, r_irq, r_prev_any;
  logic [7:0]    r_sticky;
  logic          r_lv;
  logic [2:0]    r_lt, r_lp;
  logic [3:0]    w_pc;
  logic          w_flash, w_qw, w_trip, w_entry, w_tz, w_take;

  assign w_flash = cb.alert_bitmap[ALERT_FLASH_BIT];
  assign w_qw    = cb.alert_any && (int'(cb.alert_priority) >= WARN_PRIO);
  assign w_trip  = w_flash && (int'(w_pc) + 1 >= PERSIST);
  assign w_tz    = (r_timer == '0);
  assign w_take  = cb.alert_any && (cb.ack || !r_lv || (cb.alert_priority >= r_lp));

  always_ff @(posedge clk) begin
    if (rst) r_state <= CB_NORMAL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CB_NORMAL:   if (w_trip) w_state_nxt = CB_HALT;
                   else if (w_qw) w_state_nxt = CB_WARN;
      CB_WARN:     if (w_trip) w_state_nxt = CB_HALT;
                   else if (!w_qw && w_tz) w_state_nxt = CB_NORMAL;
      CB_HALT:     if (!w_flash && w_tz) w_state_nxt = CB_COOLDOWN;
      CB_COOLDOWN: if (w_flash) w_state_nxt = CB_HALT;
                   else if (w_tz) w_state_nxt = CB_NORMAL;
      default:     w_state_nxt = CB_NORMAL;
    endcase
  end

  // Entry into HALT outranks any reload or expiry of the shared timer.
  always_comb begin
    w_entry     = (w_state_nxt == CB_HALT) && (r_state != CB_HALT);
    w_timer_nxt = r_timer;
    if (w_entry) w_timer_nxt = HALT_LOAD;
    else begin
      unique case (r_state)
        CB_NORMAL:   if (w_state_nxt == CB_WARN) w_timer_nxt = HOLD_LOAD;
        CB_WARN:     if (w_qw) w_timer_nxt = HOLD_LOAD;
                     else if (!w_tz) w_timer_nxt = r_timer - TW'(1);
        CB_HALT:     if (w_flash) w_timer_nxt = HALT_LOAD;
                     else if (w_tz) w_timer_nxt = HOLD_LOAD;
                     else w_timer_nxt = r_timer - TW'(1);
        CB_COOLDOWN: if (!w_tz) w_timer_nxt = r_timer - TW'(1);
        default:     w_timer_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer    <= '0;
      r_halt     <= 1'b0;
      r_irq      <= 1'b0;
      r_prev_any <= 1'b0;
      r_sticky   <= '0;
      r_lv       <= 1'b0;
      r_lt       <= '0;
      r_lp       <= '0;
    end else begin
      r_timer    <= w_timer_nxt;
      r_halt     <= (w_state_nxt == CB_HALT);
      r_irq      <= w_entry;
      r_prev_any <= cb.alert_any;
      r_sticky   <= (cb.ack ? 8'h00 : r_sticky) | cb.alert_bitmap;
      if (w_take) begin
        r_lv <= 1'b1;
        r_lt <= cb.alert_type;
        r_lp <= cb.alert_priority;
      end else if (cb.ack) begin
        r_lv <= 1'b0;
        r_lt <= '0;
        r_lp <= '0;
      end
    end
  end

  nt_sat_counter #(.WIDTH(4), .MAX(PERSIST)) u_pc (
    .clk(clk), .rst(rst), .i_inc(w_flash), .i_clr(!w_flash), .o_count(w_pc)
  );

  nt_sat_counter #(.WIDTH(8), .MAX(255)) u_evt (
    .clk(clk), .rst(rst), .i_inc(cb.alert_any && !r_prev_any), .i_clr(cb.ack),
    .o_count(cb.event_count)
  );

  nt_sat_counter #(.WIDTH(4), .MAX(15)) u_halt (
    .clk(clk), .rst(rst), .i_inc(w_entry), .i_clr(1'b0), .o_count(cb.halt_count)
  );

  assign cb.trade_halt    = r_halt;
  assign cb.halt_irq      = r_irq;
  assign cb.state         = r_state;
  assign cb.sticky_bitmap = r_sticky;
  assign cb.latched_valid = r_lv;
  assign cb.latched_type  = r_lt;
  assign cb.latched_prio  = r_lp;

endmodule

// File: tb/tb_alert_circuit_breaker.sv
// Bench for alert_circuit_breaker: directed scenarios plus random traffic,
// every cycle compared against a cycles-remaining behavioural model.
module tb_alert_circuit_breaker;

  localparam int PERSIST = 4;
  localparam int HOLD    = 64;
  localparam int HALTC   = 256;
  localparam int WPRIO   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alert_circuit_breaker_if cb ();

  alert_circuit_breaker #(
    .PERSIST(PERSIST), .HOLD_CYCLES(HOLD), .HALT_CYCLES(HALTC), .WARN_PRIO(WPRIO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .cb (cb)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model: state as 0..3, m_left = cycles still to spend in a timed state
  int   m_state, m_left, m_run, m_evt, m_hcnt, m_lt, m_lp;
  bit   m_prev, m_lv, m_halt, m_irq;
  logic [7:0] m_sticky;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_run = 0; m_evt = 0; m_hcnt = 0; m_lt = 0; m_lp = 0;
    m_prev = 0; m_lv = 0; m_halt = 0; m_irq = 0; m_sticky = 8'h00;
  endtask

  task automatic enter_halt();
    m_state = 2;
    m_left  = HALTC;
    m_irq   = 1;
    if (m_hcnt < 15) m_hcnt++;
  endtask

  task automatic step(input bit r, input bit any, input int prio, input int typ,
                      input logic [7:0] bm, input bit ack);
    bit flash, trip, qw;
    if (r) begin
      model_reset();
      return;
    end
    flash = bm[7];
    m_run = flash ? m_run + 1 : 0;
    trip  = flash && (m_run >= PERSIST);
    qw    = any && (prio >= WPRIO);
    m_irq = 0;
    case (m_state)
      0: if (trip) enter_halt();
         else if (qw) begin m_state = 1; m_left = HOLD; end
      1: if (trip) enter_halt();
         else if (qw) m_left = HOLD;
         else if (m_left == 1) m_state = 0;
         else m_left--;
      2: if (flash) m_left = HALTC;
         else if (m_left == 1) begin m_state = 3; m_left = HOLD; end
         else m_left--;
      default: if (flash) enter_halt();
         else if (m_left == 1) m_state = 0;
         else m_left--;
    endcase
    m_halt   = (m_state == 2);
    m_sticky = (ack ? 8'h00 : m_sticky) | bm;
    m_evt    = (ack ? 0 : m_evt) + ((any && !m_prev) ? 1 : 0);
    if (m_evt > 255) m_evt = 255;
    m_prev = any;
    if (any && (ack || !m_lv || prio >= m_lp)) begin
      m_lv = 1; m_lt = typ; m_lp = prio;
    end else if (ack) begin
      m_lv = 0; m_lt = 0; m_lp = 0;
    end
  endtask

  task automatic compare_all();
    check("state",    cb.state,         m_state);
    check("halt",     cb.trade_halt,    m_halt);
    check("irq",      cb.halt_irq,      m_irq);
    check("hcnt",     cb.halt_count,    m_hcnt);
    check("evt",      cb.event_count,   m_evt);
    check("sticky",   cb.sticky_bitmap, m_sticky);
    check("lvalid",   cb.latched_valid, m_lv);
    check("ltype",    cb.latched_type,  m_lt);
    check("lprio",    cb.latched_prio,  m_lp);
  endtask

  task automatic cyc(input bit r, input bit any, input int prio, input int typ,
                     input logic [7:0] bm, input bit ack);
    @(negedge clk);
    rst               = r;
    cb.alert_any      = any;
    cb.alert_priority = prio[2:0];
    cb.alert_type     = typ[2:0];
    cb.alert_bitmap   = bm;
    cb.ack            = ack;
    step(r, any, prio, typ, bm, ack);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic flash1();
    cyc(0, 0, 0, 0, 8'h80, 0);
  endtask

  int n_halt, n_cool, n_irq, n_warn, fp;
  logic [7:0] rbm;
  bit rany;

  initial begin
    cb.alert_any = 0; cb.alert_priority = 0; cb.alert_type = 0;
    cb.alert_bitmap = 0; cb.ack = 0;
    model_reset();

    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    check("rst_state", cb.state, 0);
    check("rst_halt", cb.trade_halt, 0);

    repeat (3) flash1();
    idle();
    check("near_trip", cb.trade_halt, 0);

    repeat (3) flash1();
    check("pre_trip", cb.trade_halt, 0);
    flash1();
    check("trip_halt", cb.trade_halt, 1);
    check("trip_irq", cb.halt_irq, 1);
    check("trip_cnt", cb.halt_count, 1);
    n_halt = 1; n_cool = 0; n_irq = 1;
    for (int i = 0; i < 400; i++) begin
      idle();
      n_halt += cb.trade_halt;
      n_cool += (cb.state == 2'd3) ? 1 : 0;
      n_irq  += cb.halt_irq;
    end
    check("halt_len", n_halt, HALTC);
    check("cool_len", n_cool, HOLD);
    check("irq_once", n_irq, 1);
    check("back_normal", cb.state, 0);

    cyc(1, 0, 0, 0, 8'h00, 0);
    repeat (4) flash1();
    repeat (256) idle();
    check("in_cool", cb.state, 3);
    repeat (9) idle();
    flash1();
    check("cool_rehalt", cb.trade_halt, 1);
    check("cool_cnt", cb.halt_count, 2);
    check("cool_irq", cb.halt_irq, 1);
    repeat (330) idle();

    cyc(0, 1, 5, 1, 8'h01, 0);
    n_warn = (cb.state == 2'd1) ? 1 : 0;
    for (int i = 0; i < 80; i++) begin
      idle();
      n_warn += (cb.state == 2'd1) ? 1 : 0;
    end
    check("warn_len", n_warn, HOLD);
    cyc(0, 1, 3, 2, 8'h02, 0);
    check("low_prio", cb.state, 0);

    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 1, 2, 2, 8'h04, 0);
    cyc(0, 1, 6, 6, 8'h40, 0);
    check("latch_type", cb.latched_type, 6);
    check("latch_sticky", cb.sticky_bitmap, 8'h44);
    cyc(0, 0, 0, 0, 8'h01, 1);
    check("ack_sticky", cb.sticky_bitmap, 8'h01);
    check("ack_type", cb.latched_type, 0);

    cyc(0, 0, 0, 0, 8'h00, 1);
    repeat (300) begin
      cyc(0, 1, 0, 1, 8'h01, 0);
      idle();
    end
    check("evt_sat", cb.event_count, 255);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, 1, 0, 1, 8'h01, 0);
    check("evt_restart", cb.event_count, 1);

    repeat (4) flash1();
    repeat (99) idle();
    check("mid_halt", cb.trade_halt, 1);
    cyc(1, 0, 0, 0, 8'h00, 0);
    check("rst_mid_halt", cb.trade_halt, 0);
    check("rst_mid_state", cb.state, 0);
    check("rst_mid_hcnt", cb.halt_count, 0);
    check("rst_mid_evt", cb.event_count, 0);

    fp = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 3))
          0: fp = 0;
          1: fp = 20;
          2: fp = 70;
          default: fp = 97;
        endcase
      end
      rbm = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 99) < fp) rbm[7] = 1'b1;
      rany = ($urandom_range(0, 9) == 0) ? 1'b1 : (rbm != 8'h00);
      cyc(($urandom_range(0, 999) == 0), rany, $urandom_range(0, 7),
          $urandom_range(0, 7), rbm, ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
